tb_host_sequencer: RTL and testbench



---
 rtl/tb_host_pkg.sv | 36 +++
 rtl/tb_host_if.sv | 21 ++
 rtl/tb_host_sequencer_cycle_timer.sv | 24 ++
 rtl/tb_host_sequencer.sv | 156 +++++++++++++++
 tb/tb_tb_host_sequencer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/tb_host_pkg.sv
// Shared constants and state encoding for the arithmetic-testbench host sequencer.
// Slave register map, control word layout and the sequencer state enum.
package tb_host_pkg;

    localparam logic [3:0] ADDR_I1 = 4'd0;
    localparam logic [3:0] ADDR_I2 = 4'd1;
    localparam logic [3:0] ADDR_O1 = 4'd2;
    localparam logic [3:0] ADDR_O2 = 4'd3;
    localparam logic [3:0] ADDR_O3 = 4'd4;

    localparam int CTRL_RST_BIT = 0;
    localparam int CTRL_EN_BIT  = 1;
    localparam int CTRL_FRZ_BIT = 2;

    localparam logic [31:0] CTRL_RESET  = 32'd1 << CTRL_RST_BIT;
    localparam logic [31:0] CTRL_RUN    = 32'd1 << CTRL_EN_BIT;
    localparam logic [31:0] CTRL_FREEZE = (32'd1 << CTRL_EN_BIT) | (32'd1 << CTRL_FRZ_BIT);
    localparam logic [31:0] CTRL_CLEAR  = 32'd0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_RST,
        S_HOLD,
        S_WR_EN,
        S_RUN,
        S_WR_FRZ,
        S_SETTLE,
        S_RD1,
        S_RD2,
        S_RD3,
        S_CAP3,
        S_WR_CLR,
        S_DONE
    } state_t;

endpackage

// File: rtl/tb_host_if.sv
// Avalon-MM bus between the host sequencer (master) and the testbench wrapper slave.
// Fixed read latency of one cycle, no waitrequest.
interface tb_host_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       address;
    logic             read;
    logic             write;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] readdata;

    modport master (
        output address, read, write, writedata,
        input  readdata
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata
    );
endinterface

// File: rtl/tb_host_sequencer_cycle_timer.sv
// Load/decrement down-counter shared by the HOLD, RUN and SETTLE waits.
// zero is asserted when the count has reached terminal count.
module cycle_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        dec,
    input  logic [31:0] load_value,
    output logic        zero
);
    logic [31:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 32'd1;
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/tb_host_sequencer.sv
// Host-side Avalon master running one reset/enable/run/freeze/readback session
// against the arithmetic testbench wrapper.
module tb_host_sequencer
    import tb_host_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 8,
    parameter int EXP_VERSION   = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      run_cycles,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_data_ctr,
    output logic [WIDTH-1:0] result_event_ctr,
    output logic [WIDTH-1:0] result_version,
    output logic             version_ok,
    tb_host_if.master        m
);
    localparam logic [31:0] SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);

    state_t      state, state_next;
    logic [31:0] run_len;
    logic        t_load, t_dec, t_zero;
    logic [31:0] t_value;

    cycle_timer u_timer (
        .clk        (clk),
        .rst_n      (reset_n),
        .load       (t_load),
        .dec        (t_dec),
        .load_value (t_value),
        .zero       (t_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs decode straight from the state register so reset idles the bus asynchronously.
    always_comb begin
        state_next  = state;
        m.address   = '0;
        m.read      = 1'b0;
        m.write     = 1'b0;
        m.writedata = '0;
        busy        = 1'b1;
        done        = 1'b0;
        t_load      = 1'b0;
        t_dec       = 1'b0;
        t_value     = '0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_next = S_WR_RST;
            end
            S_WR_RST: begin
                m.write     = 1'b1;
                m.address   = ADDR_I1;
                m.writedata = WIDTH'(CTRL_RESET);
                t_load      = 1'b1;
                t_value     = SETTLE_LOAD;
                state_next  = S_HOLD;
            end
            S_HOLD: begin
                if (t_zero) state_next = S_WR_EN;
                else        t_dec      = 1'b1;
            end
            S_WR_EN: begin
                m.write     = 1'b1;
                m.address   = ADDR_I1;
                m.writedata = WIDTH'(CTRL_RUN);
                if (run_len == '0) begin
                    state_next = S_WR_FRZ;
                end else begin
                    t_load     = 1'b1;
                    t_value    = run_len - 32'd1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (abort || t_zero) state_next = S_WR_FRZ;
                else                 t_dec      = 1'b1;
            end
            S_WR_FRZ: begin
                m.write     = 1'b1;
                m.address   = ADDR_I1;
                m.writedata = WIDTH'(CTRL_FREEZE);
                t_load      = 1'b1;
                t_value     = SETTLE_LOAD;
                state_next  = S_SETTLE;
            end
            S_SETTLE: begin
                if (t_zero) state_next = S_RD1;
                else        t_dec      = 1'b1;
            end
            S_RD1: begin
                m.read     = 1'b1;
                m.address  = ADDR_O1;
                state_next = S_RD2;
            end
            S_RD2: begin
                m.read     = 1'b1;
                m.address  = ADDR_O2;
                state_next = S_RD3;
            end
            S_RD3: begin
                m.read     = 1'b1;
                m.address  = ADDR_O3;
                state_next = S_CAP3;
            end
            S_CAP3: state_next = S_WR_CLR;
            S_WR_CLR: begin
                m.write     = 1'b1;
                m.address   = ADDR_I1;
                m.writedata = WIDTH'(CTRL_CLEAR);
                state_next  = S_DONE;
            end
            S_DONE: begin
                busy       = 1'b0;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    // Read data lags the strobe by one cycle, so each capture sits one state after its read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_len          <= '0;
            result_data_ctr  <= '0;
            result_event_ctr <= '0;
            result_version   <= '0;
            version_ok       <= 1'b0;
        end else begin
            if (state == S_IDLE && start) run_len <= run_cycles;
            if (state == S_RD2) result_data_ctr  <= m.readdata;
            if (state == S_RD3) result_event_ctr <= m.readdata;
            if (state == S_CAP3) begin
                result_version <= m.readdata;
                version_ok     <= (m.readdata == WIDTH'(EXP_VERSION));
            end
        end
    end
endmodule

// File: tb/tb_tb_host_sequencer.sv
// Self-checking bench for tb_host_sequencer: table-driven and random sessions against
// a schedule model derived from the session timing rules, plus a mid-session reset.
module tb_tb_host_sequencer;
    localparam int WIDTH  = 32;
    localparam int S      = 8;
    localparam int EXPVER = 7;

    typedef struct {
        int          rc;
        int          abort_at;
        int          extra_start;
        logic [31:0] dv;
        logic [31:0] ev;
        logic [31:0] vv;
    } vec_t;

    typedef struct {
        int          c;
        logic [3:0]  a;
        logic [31:0] d;
    } acc_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [31:0]      run_cycles = '0;
    logic             busy, done, version_ok;
    logic [WIDTH-1:0] res_d, res_e, res_v;

    tb_host_if #(.WIDTH(WIDTH)) bus ();

    tb_host_sequencer #(.WIDTH(WIDTH), .SETTLE_CYCLES(S), .EXP_VERSION(EXPVER)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .abort            (abort),
        .run_cycles       (run_cycles),
        .busy             (busy),
        .done             (done),
        .result_data_ctr  (res_d),
        .result_event_ctr (res_e),
        .result_version   (res_v),
        .version_ok       (version_ok),
        .m                (bus)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          t0 = 0;
    logic [31:0] slave_regs [16];
    logic [31:0] slave_ctrl = '0;
    acc_t        wq[$];
    acc_t        rq[$];
    int          done_cnt, done_cyc, busy_cnt, viol;
    int          n_pass = 0;
    int          n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: one-cycle read latency, control register survives host reset.
    always @(posedge clk) begin
        if (bus.write && bus.address == 4'd0) slave_ctrl <= bus.writedata;
        if (bus.read) bus.readdata <= slave_regs[bus.address];
    end

    always @(negedge clk) begin
        int rel;
        rel = cyc - t0;
        if (bus.write) wq.push_back('{rel, bus.address, bus.writedata});
        if (bus.read)  rq.push_back('{rel, bus.address, 32'd0});
        if (bus.read && bus.write) viol++;
        if (!bus.read && !bus.write && (bus.address != 4'd0 || bus.writedata != '0)) viol++;
        if (done) begin
            done_cnt++;
            done_cyc = rel;
        end
        if (busy) busy_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic run_session(input vec_t v, input int id);
        int   rel, f, ws, rs;
        acc_t ew[4];
        acc_t er[3];
        slave_regs[2] = v.dv;
        slave_regs[3] = v.ev;
        slave_regs[4] = v.vv;
        wq.delete();
        rq.delete();
        done_cnt = 0;
        done_cyc = -1;
        busy_cnt = 0;
        viol     = 0;
        run_cycles = v.rc;
        start = 1'b1;
        abort = (v.abort_at == 0);
        t0 = cyc;
        for (int i = 0; i < v.rc + 300; i++) begin
            @(negedge clk); #1;
            rel   = cyc - t0;
            start = (rel == v.extra_start);
            abort = (rel == v.abort_at);
            if (done_cyc >= 0 && rel >= done_cyc + 1) break;
        end
        start = 1'b0;
        abort = 1'b0;

        // Freeze lands right after RUN ends, or one cycle after an abort seen inside RUN.
        if (v.rc > 0 && v.abort_at >= 3 + S && v.abort_at <= 2 + S + v.rc) f = v.abort_at + 1;
        else f = 3 + S + v.rc;
        ew[0] = '{1, 4'd0, 32'h1};
        ew[1] = '{2 + S, 4'd0, 32'h2};
        ew[2] = '{f, 4'd0, 32'h6};
        ew[3] = '{f + 5 + S, 4'd0, 32'h0};
        er[0] = '{f + 1 + S, 4'd2, 32'd0};
        er[1] = '{f + 2 + S, 4'd3, 32'd0};
        er[2] = '{f + 3 + S, 4'd4, 32'd0};

        ws = wq.size();
        rs = rq.size();
        check($sformatf("s%0d write count", id), ws, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("s%0d write%0d cycle", id, i), (i < ws) ? wq[i].c : -1, ew[i].c);
            check($sformatf("s%0d write%0d addr", id, i), (i < ws) ? wq[i].a : 4'hf, ew[i].a);
            check($sformatf("s%0d write%0d data", id, i), (i < ws) ? wq[i].d : 32'hdead, ew[i].d);
        end
        check($sformatf("s%0d read count", id), rs, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("s%0d read%0d cycle", id, i), (i < rs) ? rq[i].c : -1, er[i].c);
            check($sformatf("s%0d read%0d addr", id, i), (i < rs) ? rq[i].a : 4'hf, er[i].a);
        end
        check($sformatf("s%0d done cycle", id), done_cyc, f + 6 + S);
        check($sformatf("s%0d done pulses", id), done_cnt, 1);
        check($sformatf("s%0d busy cycles", id), busy_cnt, f + 5 + S);
        check($sformatf("s%0d bus idle rules", id), viol, 0);
        check($sformatf("s%0d data ctr", id), res_d, v.dv);
        check($sformatf("s%0d event ctr", id), res_e, v.ev);
        check($sformatf("s%0d version", id), res_v, v.vv);
        check($sformatf("s%0d version ok", id), version_ok, (v.vv == EXPVER));
    endtask

    vec_t tbl[8];
    vec_t rv;

    initial begin
        tbl[0] = '{100, -1,     -1, 32'd100, 32'd3,  32'd7};
        tbl[1] = '{0,   -1,     -1, 32'd5,   32'd9,  32'd7};
        tbl[2] = '{1000, 30,    -1, 32'd11,  32'd22, 32'd7};
        tbl[3] = '{20,  -1,     -1, 32'd12,  32'd34, 32'd6};
        tbl[4] = '{30,  -1,      5, 32'd77,  32'd88, 32'd7};
        tbl[5] = '{15,   0,     -1, 32'd1,   32'd2,  32'd7};
        tbl[6] = '{1,   -1,     -1, 32'd40,  32'd41, 32'd7};
        tbl[7] = '{10,  3 + S,  -1, 32'd44,  32'd55, 32'd7};
        for (int i = 0; i < 16; i++) slave_regs[i] = 32'(i) * 32'd1000;

        repeat (3) @(negedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset strobes", {bus.read, bus.write}, 0);
        check("reset address", bus.address, 0);
        check("reset results", {res_d, res_e, res_v, version_ok}, 0);
        reset_n = 1'b1;
        @(negedge clk); #1;

        for (int i = 0; i < 8; i++) run_session(tbl[i], i);

        // Reset in the middle of RUN: everything drops without waiting for a clock edge.
        slave_regs[2] = 32'd9;
        run_cycles = 100;
        start = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            start = 1'b0;
            if (cyc - t0 >= 50) break;
        end
        check("pre-reset busy", busy, 1);
        check("pre-reset data ctr", res_d, 32'd44);
        reset_n = 1'b0;
        #1;
        check("async reset busy", busy, 0);
        check("async reset strobes", {bus.read, bus.write, done}, 0);
        check("async reset results", {res_d, res_e, res_v, version_ok}, 0);
        @(negedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk); #1;
        run_session('{25, -1, -1, 32'd123, 32'd456, 32'd7}, 100);

        for (int i = 0; i < 8; i++) begin
            rv.rc          = int'($urandom_range(0, 60));
            rv.abort_at    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, rv.rc + 14)) : -1;
            rv.extra_start = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 2 + S)) : -1;
            rv.dv          = $urandom;
            rv.ev          = $urandom;
            rv.vv          = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 15)) : 32'd7;
            run_session(rv, 200 + i);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
